// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin 2:1 mux arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT_A = 2'b01,
        ST_GRANT_B = 2'b10
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Beat counter width: enough bits to count 0..max_burst-1, never narrower than 1.
    function automatic int bcnt_width(input int max_burst);
        return (max_burst <= 2) ? 1 : $clog2(max_burst);
    endfunction

endpackage

// File: rtl/mux_2_to_1.sv
// Single-bit 2:1 multiplexer, i_sel=0 picks i_a, i_sel=1 picks i_b.
// Latency: combinational.
// Backpressure: none; pure datapath.
module mux_2_to_1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux_2_to_1_arbiter.sv
// Round-robin arbiter steering two requesters through a shared 2:1 mux to one consumer.
// Latency: grant one cycle after a request is seen in IDLE; data path combinational from the grant.
// Backpressure: OUT_READY=0 stalls state, beat count and select; burst limit only applies under contention.
module mux_2_to_1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ_A,
    input  logic             REQ_B,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             GNT_A,
    output logic             GNT_B,
    output logic             SEL,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUTPUT,
    output logic [WIDTH-1:0] OUTPUT_BAR
);

    localparam int            BW        = bcnt_width(MAX_BURST);
    localparam logic [BW-1:0] BCNT_LAST = BW'(MAX_BURST - 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_last;
    logic            w_last_next;
    logic [BW-1:0]   r_bcnt;
    logic [BW-1:0]   w_bcnt_next;
    logic            w_xfer;
    logic            w_burst_end;
    logic [WIDTH-1:0] w_mux;

    // Grant and select are pure decodes of the state register, so they cannot glitch.
    assign GNT_A = (r_state == ST_GRANT_A);
    assign GNT_B = (r_state == ST_GRANT_B);
    assign SEL   = (r_state == ST_GRANT_B) ? SEL_B : SEL_A;

    assign OUT_VALID   = (GNT_A & REQ_A) | (GNT_B & REQ_B);
    assign w_xfer      = OUT_VALID & OUT_READY;
    assign w_burst_end = w_xfer && (r_bcnt == BCNT_LAST);

    // Next-state: round-robin tie break in IDLE, direct handover on release or burst limit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (REQ_A && REQ_B)
                    w_next = (r_last == SEL_B) ? ST_GRANT_A : ST_GRANT_B;
                else if (REQ_A)
                    w_next = ST_GRANT_A;
                else if (REQ_B)
                    w_next = ST_GRANT_B;
            end
            ST_GRANT_A: begin
                if (!REQ_A)
                    w_next = REQ_B ? ST_GRANT_B : ST_IDLE;
                else if (w_burst_end && REQ_B)
                    w_next = ST_GRANT_B;
            end
            ST_GRANT_B: begin
                if (!REQ_B)
                    w_next = REQ_A ? ST_GRANT_A : ST_IDLE;
                else if (w_burst_end && REQ_A)
                    w_next = ST_GRANT_A;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Beat counter and last-winner: restart on any state change, count accepted beats while holding.
    always_comb begin
        w_last_next = r_last;
        w_bcnt_next = r_bcnt;
        if (w_next != r_state) begin
            w_bcnt_next = '0;
            if (w_next == ST_GRANT_A)
                w_last_next = SEL_A;
            else if (w_next == ST_GRANT_B)
                w_last_next = SEL_B;
        end else if (w_xfer) begin
            // Uncontested side wraps and keeps the grant.
            w_bcnt_next = (r_bcnt == BCNT_LAST) ? '0 : r_bcnt + BW'(1);
        end
    end

    // State registers with synchronous active-low reset; B marked last so A wins the first tie.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_last  <= SEL_B;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_last  <= w_last_next;
            r_bcnt  <= w_bcnt_next;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux_2_to_1 u_mux (
            .i_a   (A[i]),
            .i_b   (B[i]),
            .i_sel (SEL),
            .o_y   (w_mux[i])
        );
    end

    // Bus reads as zero whenever no beat is offered.
    assign OUTPUT     = OUT_VALID ? w_mux : '0;
    assign OUTPUT_BAR = ~OUTPUT;

endmodule

// File: tb/tb_mux_2_to_1_arbiter.sv
// Self-checking bench for mux_2_to_1_arbiter with an expected-beat scoreboard.
// Latency: inputs driven 1 time unit after rising edge, outputs sampled on falling edge.
// Backpressure: OUT_READY driven by the scenario tasks.
module tb_mux_2_to_1_arbiter;

    logic       CLK;
    logic       RST_N;
    logic       REQ_A;
    logic       REQ_B;
    logic [7:0] A;
    logic [7:0] B;
    logic       GNT_A;
    logic       GNT_B;
    logic       SEL;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] OUTPUT;
    logic [7:0] OUTPUT_BAR;

    int         total;
    int         bad;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    mux_2_to_1_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .REQ_A      (REQ_A),
        .REQ_B      (REQ_B),
        .A          (A),
        .B          (B),
        .GNT_A      (GNT_A),
        .GNT_B      (GNT_B),
        .SEL        (SEL),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUTPUT     (OUTPUT),
        .OUTPUT_BAR (OUTPUT_BAR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Scoreboard: every accepted beat must match the oldest expected value.
    always @(negedge CLK) begin
        if (RST_N && OUT_VALID && OUT_READY) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got %h, expected no beat", OUTPUT);
            end else begin
                exp_v = exp_q.pop_front();
                if (OUTPUT !== exp_v || OUTPUT_BAR !== ~exp_v) begin
                    bad++;
                    $display("FAIL sb_beat: got %h/%h, expected %h/%h", OUTPUT, OUTPUT_BAR, exp_v, ~exp_v);
                end
            end
        end
    end

    // Drop both requests from the posedge+1 phase, confirm IDLE and an empty scoreboard.
    task automatic go_idle(input string name);
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        total++;
        if (GNT_A !== 1'b0 || GNT_B !== 1'b0 || OUT_VALID !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: gnt_a=%b gnt_b=%b valid=%b, expected 0 0 0", name, GNT_A, GNT_B, OUT_VALID);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, exp_q.size());
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; REQ_A = 1'b1; REQ_B = 1'b1;
        A = 8'hA5; B = 8'h5A; OUT_READY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            total++;
            if (GNT_A !== 1'b0 || GNT_B !== 1'b0 || SEL !== 1'b0 || OUT_VALID !== 1'b0 ||
                OUTPUT !== 8'h00 || OUTPUT_BAR !== 8'hFF) begin
                bad++;
                $display("FAIL reset_state: gnt=%b%b sel=%b valid=%b out=%h bar=%h, expected 00 0 0 00 ff",
                         GNT_A, GNT_B, SEL, OUT_VALID, OUTPUT, OUTPUT_BAR);
            end
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        total++;
        if (GNT_A !== 1'b0) begin
            bad++;
            $display("FAIL reset_latency: gnt_a=%b, expected 0", GNT_A);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        total++;
        if (GNT_A !== 1'b1 || GNT_B !== 1'b0 || SEL !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_tie: gnt=%b%b sel=%b, expected 10 0", GNT_A, GNT_B, SEL);
        end
        @(posedge CLK); #1;
        go_idle("reset");
    endtask

    task automatic test_single_requester();
        for (int i = 0; i < 10; i++) exp_q.push_back(8'h5A);
        A = 8'h5A; B = 8'hC3; REQ_A = 1'b1; REQ_B = 1'b0; OUT_READY = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            total++;
            if (i == 0) begin
                if (GNT_A !== 1'b0 || OUT_VALID !== 1'b0) begin
                    bad++;
                    $display("FAIL single_idle: gnt_a=%b valid=%b, expected 0 0", GNT_A, OUT_VALID);
                end
            end else if (GNT_A !== 1'b1 || GNT_B !== 1'b0 || OUTPUT !== 8'h5A) begin
                bad++;
                $display("FAIL single_hold c%0d: gnt=%b%b out=%h, expected 10 5a", i, GNT_A, GNT_B, OUTPUT);
            end
            @(posedge CLK); #1;
        end
        REQ_A = 1'b0;
        @(negedge CLK);
        total++;
        if (OUT_VALID !== 1'b0 || OUTPUT !== 8'h00 || OUTPUT_BAR !== 8'hFF) begin
            bad++;
            $display("FAIL single_gate: valid=%b out=%h bar=%h, expected 0 00 ff", OUT_VALID, OUTPUT, OUTPUT_BAR);
        end
        @(posedge CLK); #1;
        go_idle("single");
    endtask

    task automatic test_contention();
        // Previous grant was A, so B wins the opening tie.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) exp_q.push_back(k[0] ? 8'h11 : 8'h22);
        end
        A = 8'h11; B = 8'h22; REQ_A = 1'b1; REQ_B = 1'b1; OUT_READY = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge CLK);
            if (i > 0) begin
                total++;
                if (SEL !== (((i - 1) / 4) % 2 == 0) || OUT_VALID !== 1'b1) begin
                    bad++;
                    $display("FAIL contention_sel c%0d: sel=%b valid=%b, expected %b 1",
                             i, SEL, OUT_VALID, (((i - 1) / 4) % 2 == 0));
                end
            end
            @(posedge CLK); #1;
        end
        go_idle("contention");
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h44);
        A = 8'h44; B = 8'h33; REQ_A = 1'b0; REQ_B = 1'b1; OUT_READY = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        REQ_A = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            total++;
            if (GNT_B !== 1'b1) begin
                bad++;
                $display("FAIL bp_pre c%0d: gnt_b=%b, expected 1", i, GNT_B);
            end
            @(posedge CLK); #1;
        end
        OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if (GNT_B !== 1'b1 || SEL !== 1'b1 || OUT_VALID !== 1'b1 || OUTPUT !== 8'h33) begin
                bad++;
                $display("FAIL bp_stall c%0d: gnt_b=%b sel=%b valid=%b out=%h, expected 1 1 1 33",
                         i, GNT_B, SEL, OUT_VALID, OUTPUT);
            end
            @(posedge CLK); #1;
        end
        OUT_READY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            total++;
            if (GNT_B !== 1'b1) begin
                bad++;
                $display("FAIL bp_post c%0d: gnt_b=%b, expected 1", i, GNT_B);
            end
            @(posedge CLK); #1;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            total++;
            if (GNT_A !== 1'b1 || SEL !== 1'b0) begin
                bad++;
                $display("FAIL bp_handover c%0d: gnt_a=%b sel=%b, expected 1 0", i, GNT_A, SEL);
            end
            @(posedge CLK); #1;
        end
        go_idle("bp");
    endtask

    task automatic test_early_release();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h55);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h66);
        exp_q.push_back(8'h55);
        A = 8'h55; B = 8'h66; REQ_A = 1'b1; REQ_B = 1'b0; OUT_READY = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        REQ_B = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            total++;
            if (GNT_A !== 1'b1) begin
                bad++;
                $display("FAIL early_a c%0d: gnt_a=%b, expected 1", i, GNT_A);
            end
            @(posedge CLK); #1;
        end
        REQ_A = 1'b0;
        @(negedge CLK);
        total++;
        if (GNT_A !== 1'b1 || OUT_VALID !== 1'b0) begin
            bad++;
            $display("FAIL early_drop: gnt_a=%b valid=%b, expected 1 0", GNT_A, OUT_VALID);
        end
        @(posedge CLK); #1;
        REQ_A = 1'b1;
        // Full four-beat B burst shows the counter restarted on handover.
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            total++;
            if (GNT_B !== 1'b1) begin
                bad++;
                $display("FAIL early_b c%0d: gnt_b=%b, expected 1", i, GNT_B);
            end
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        total++;
        if (GNT_A !== 1'b1) begin
            bad++;
            $display("FAIL early_back: gnt_a=%b, expected 1", GNT_A);
        end
        @(posedge CLK); #1;
        go_idle("early");
    endtask

    task automatic test_reset_mid_burst();
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h88);
        A = 8'h88; B = 8'h77; REQ_A = 1'b0; REQ_B = 1'b1; OUT_READY = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        REQ_A = 1'b1;
        @(negedge CLK);
        total++;
        if (GNT_B !== 1'b1) begin
            bad++;
            $display("FAIL midrst_b: gnt_b=%b, expected 1", GNT_B);
        end
        @(posedge CLK); #1;
        RST_N = 1'b0;
        @(negedge CLK);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        total++;
        if (GNT_A !== 1'b0 || GNT_B !== 1'b0 || OUT_VALID !== 1'b0) begin
            bad++;
            $display("FAIL midrst_idle: gnt=%b%b valid=%b, expected 00 0", GNT_A, GNT_B, OUT_VALID);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        total++;
        if (GNT_A !== 1'b1 || OUTPUT !== 8'h88) begin
            bad++;
            $display("FAIL midrst_a_first: gnt_a=%b out=%h, expected 1 88", GNT_A, OUTPUT);
        end
        @(posedge CLK); #1;
        go_idle("midrst");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_requester();
        test_contention();
        test_back_pressure();
        test_early_release();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_2_to_1_arbiter.md
Name: mux_2_to_1_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 2:1 mux datapath.
- Two requesters (A, B) each present data plus a request.
- The arbiter drives SEL, grants one requester at a time, and presents the selected data with a valid/ready handshake to a single downstream consumer.
- Burst length per grant is bounded so neither requester can starve the other.

Parameters:
- WIDTH, 8, data width of A, B, OUTPUT, OUTPUT_BAR.
- MAX_BURST, 4, maximum accepted beats per grant while the other requester is waiting (≥1).

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  synchronous reset, active low
- REQ_A  in  1  requester A has a beat on A
- REQ_B  in  1  requester B has a beat on B
- A  in  WIDTH  requester A data
- B  in  WIDTH  requester B data
- GNT_A  out  1  A owns the mux (registered)
- GNT_B  out  1  B owns the mux (registered)
- SEL  out  1  mux select, 0=A, 1=B (registered)
- OUT_VALID  out  1  OUTPUT holds a valid beat
- OUT_READY  in  1  consumer accepts a beat
- OUTPUT  out  WIDTH  selected data, 0 when OUT_VALID=0
- OUTPUT_BAR  out  WIDTH  bitwise ~OUTPUT

Behaviour:
- States: IDLE, GRANT_A, GRANT_B. Registers: state, LAST (last granted side), beat counter BCNT (range 0..MAX_BURST-1).
- Reset (RST_N=0 at a CLK edge): state=IDLE, LAST=B (so A wins first tie), BCNT=0, GNT_A=GNT_B=0, SEL=0. The cycle after reset: OUT_VALID=0, OUTPUT=0, OUTPUT_BAR=all ones. Reset mid-burst drops the grant immediately; the in-flight beat is not transferred.
- Decoding: GNT_A=(state==GRANT_A), GNT_B=(state==GRANT_B), SEL=(state==GRANT_B). All are state-decoded and glitch-free.
- OUT_VALID = (GRANT_A & REQ_A) | (GRANT_B & REQ_B). This is combinational from the registered grant.
- OUTPUT = SEL ? B : A when OUT_VALID, else 0.
- Transfer beat: OUT_VALID & OUT_READY at a rising edge.
- IDLE transitions:
  - Only REQ_A → GRANT_A.
  - Only REQ_B → GRANT_B.
  - Both → side opposite LAST.
  - Neither → stay.
- Grant latency: a request seen in IDLE produces its grant on the following cycle (1 cycle). No beat transfers in IDLE.
- GRANT_x transitions, evaluated at each edge (y = the other side):
  - REQ_x=0 and REQ_y=1 → GRANT_y.
  - REQ_x=0 and REQ_y=0 → IDLE.
  - Transfer, BCNT==MAX_BURST-1, and REQ_y=1 → GRANT_y (burst limit hit).
  - Otherwise stay.
- Handover between requesters costs 0 idle cycles: GRANT_x goes directly to GRANT_y.
- On every entry to GRANT_x: LAST←x, BCNT←0.
- While staying in GRANT_x: BCNT increments on each transfer.
- BCNT at MAX_BURST-1 with a transfer and REQ_y=0: BCNT wraps to 0 and the grant is retained; no forced release without competition.
- Stall (OUT_VALID=1, OUT_READY=0): state, BCNT and SEL hold; OUTPUT tracks the granted input.
- Requesters must hold data stable while REQ is high and the beat is unaccepted. The arbiter does not latch data.
- Simultaneous REQ_y rise and last beat of burst in the same cycle: REQ_y is sampled at that edge, so handover occurs.
- MAX_BURST=1: strict alternation whenever both request.

Decomposition:
- Shared package mux_arb_pkg holds:
  - state encodings ST_IDLE=2'b00, ST_GRANT_A=2'b01, ST_GRANT_B=2'b10;
  - SEL_A=1'b0, SEL_B=1'b1;
  - a function computing BCNT width, clog2(MAX_BURST) with minimum 1.
- The datapath is WIDTH instances of the existing mux_2_to_1 in a generate loop (A, B, SEL per bit).
- The arbiter gates the mux result with OUT_VALID and generates OUTPUT_BAR.
- The FSM and counter stay in the top module; no further sub-modules.

Test Plan:
- Reset: RST_N=0 for 2 cycles with REQ_A=REQ_B=1 → GNT_A=GNT_B=0, SEL=0, OUT_VALID=0, OUTPUT=8'h00, OUTPUT_BAR=8'hFF. After release, GNT_A=1 one cycle later (LAST=B).
- Single requester: REQ_A=1, A=8'h5A, OUT_READY=1 for 10 cycles, REQ_B=0 → GNT_A held throughout, OUTPUT=8'h5A each cycle, no release at beat 4. Then REQ_A=0 → IDLE next cycle.
- Contention, MAX_BURST=4: REQ_A=REQ_B=1, OUT_READY=1, A=8'h11, B=8'h22 → 4 beats of 8'h11, then 4 of 8'h22, repeating. SEL toggles with no idle cycle between bursts.
- Back-pressure: in GRANT_B, hold OUT_READY=0 for 3 cycles with REQ_A=1 → SEL=1 and BCNT unchanged. Stalled cycles are not counted; handover happens only after the 4th accepted beat.
- Early release: GRANT_A after 2 beats, REQ_A drops while REQ_B=1 → GNT_B=1 at the next edge and BCNT=0.
- Reset mid-burst: RST_N=0 during GRANT_B beat 2 → IDLE next cycle, LAST=B. With both requests still high, A is granted first after reset.
